event_latch16: RTL and testbench
================================

Name: event_latch16

Overview:
- 16-channel sticky event capture stage. Feeds its masked pending bus into `multigate_or16` to form a single interrupt/attention line.
- Converts raw level or edge events into latched pending flags, with per-bit mask and write-1-to-clear.
- Also reports the lowest-index active pending channel, so downstream logic can service it.

Parameters:
- WIDTH, 16, number of event channels. Fixed at 16 because `pend_masked` drives `multigate_or16`; other values are illegal.
- ID_W, 4, width of `first_id` (log2 of WIDTH).

Ports:
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- ev_in  input  16  raw event inputs, synchronous to clk
- edge_mode  input  16  per bit: 1 = rising-edge detect, 0 = level detect
- mask  input  16  per bit: 1 = channel enabled toward irq/first_id
- clr  input  16  write-1-to-clear pulses for pend
- pend  output  16  sticky pending flags, captured regardless of mask
- pend_masked  output  16  pend & mask, combinational; bus into multigate_or16
- irq  output  1  registered OR of pend_masked
- first_vld  output  1  registered: at least one pend_masked bit set
- first_id  output  4  registered index of the lowest set pend_masked bit; 0 when first_vld = 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: pend, the prev-sample register, irq, first_vld and first_id all clear to 0 immediately on rst_n low.
- Asserting rst_n mid-operation discards all pending state. No event is recorded while rst_n is low.
- Hit detection, per bit i: hit[i] = edge_mode[i] ? (ev_in[i] & ~prev[i]) : ev_in[i].
- prev <= ev_in every cycle, independent of edge_mode. Switching a channel to edge mode therefore never creates a false hit from a level that is already high.
- Update: pend <= (pend & ~clr) | hit.
- Set beats clear: a hit and a clr on the same bit in the same cycle leave the bit set.
- Level mode: pend re-sets every cycle while ev_in is high. A clr has no lasting effect until the input drops.
- Mask gates only pend_masked, irq and first_*. A masked channel still latches into pend, and unmasking it later asserts irq on the next cycle.
- Latency:
  - ev_in sampled at edge N -> pend visible after edge N.
  - pend_masked is combinational on pend.
  - irq, first_vld and first_id update after edge N+1.
  - clr at edge N -> pend bit low after N (if no concurrent hit) -> irq low after N+1.
- irq_d = multigate_or16(pend_masked), registered into irq.
- first_id is a priority encode with bit 0 highest priority. It is registered together with first_vld.
- All-clear boundary: when pend_masked = 0, irq = 0, first_vld = 0 and first_id = 0.
- All-set boundary: when pend_masked = FFFF, first_id = 0.
- clr on a bit that is already clear has no effect.
- No counters wrap. The block holds no overflow state; multiple hits on a pending bit collapse into one flag.

Optional Feature:
- Macro: EVENT_LATCH16_SYNC_EN.
- Defined: ev_in passes through a 2-flop synchronizer (reset 0) before hit detection. ev_in may then be asynchronous. Capture latency grows by 2 cycles: pend after edge N+2, irq after N+3.
- Undefined: ev_in feeds hit detection directly and must be synchronous to clk.

Decomposition:
- Package event_latch16_pkg: WIDTH = 16 and ID_W = 4 as constants, plus a 16-bit channel-vector typedef.
- Sub-module event_latch16_prienc: combinational 16-to-4 lowest-index priority encoder with a valid output.
- Instantiate the existing multigate_or16 for irq_d; do not re-implement the reduction.

Test Plan:
- Reset: hold rst_n = 0 with ev_in = FFFF -> pend = 0000, irq = 0, first_vld = 0; release -> level-mode bits latch on the next edge.
- Edge capture: edge_mode = FFFF, mask = FFFF, pulse ev_in[5] for 1 cycle -> pend = 0020 after edge N, irq = 1 and first_id = 5 after N+1. Hold ev_in[5] high afterwards -> no new hit once cleared.
- Set beats clear: pend[3] = 1, drive clr[3] = 1 with a new rising edge on ev_in[3] in the same cycle -> pend[3] stays 1. Next cycle, clr[3] alone -> pend[3] = 0, irq = 0 one cycle later.
- Mask: mask = 0000, event on bit 9 -> pend = 0200, irq = 0. Set mask[9] = 1 -> irq = 1 and first_id = 9 after the next edge.
- Priority: pend = 8410 with mask = FFFF -> first_id = 4. Clear bit 4 -> first_id = 10. Clear bit 10 -> first_id = 15. Clear bit 15 -> first_vld = 0 and first_id = 0.
- Sync feature: with EVENT_LATCH16_SYNC_EN defined, pulse ev_in[0] for 1 cycle -> pend[0] = 1 after edge N+2 and irq after N+3. Without the macro -> pend[0] after N and irq after N+1.

Source files
------------

// File: rtl/event_latch16_pkg.sv
// rtl/event_latch16_pkg.sv - shared constants and channel vector type for event_latch16
package event_latch16_pkg;

    localparam int WIDTH = 16;
    localparam int ID_W  = 4;

    typedef logic [WIDTH-1:0] chan_vec_t;
    typedef logic [ID_W-1:0]  chan_id_t;

endpackage

// File: rtl/event_latch16_prienc.sv
// rtl/event_latch16_prienc.sv - combinational 16-to-4 priority encoder, bit 0 highest priority
module event_latch16_prienc
    import event_latch16_pkg::*;
(
    input  chan_vec_t req,
    output logic      vld,
    output chan_id_t  id
);

    // Scanning from the top down lets the lowest set bit make the final assignment.
    always_comb begin
        vld = |req;
        id  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = chan_id_t'(i);
            end
        end
    end

endmodule

// File: rtl/multigate_or16.sv
// rtl/multigate_or16.sv - 16-input OR reduction shared by attention/interrupt aggregators
module multigate_or16 (
    input  logic [15:0] a,
    output logic        y
);

    assign y = |a;

endmodule

// File: rtl/event_latch16.sv
// rtl/event_latch16.sv - 16-channel sticky event latch with mask, W1C and first-pending index; EVENT_LATCH16_SYNC_EN adds a 2-flop input synchronizer
module event_latch16
    import event_latch16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ev_in,
    input  logic [WIDTH-1:0] edge_mode,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] pend,
    output logic [WIDTH-1:0] pend_masked,
    output logic             irq,
    output logic             first_vld,
    output logic [ID_W-1:0]  first_id
);

    logic [WIDTH-1:0] ev_s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] hit;
    logic             irq_d;
    logic             enc_vld;
    chan_id_t         enc_id;

`ifdef EVENT_LATCH16_SYNC_EN
    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= ev_in;
            sync_q2 <= sync_q1;
        end
    end

    assign ev_s = sync_q2;
`else
    assign ev_s = ev_in;
`endif

    // prev tracks the input in every mode, so flipping a channel to edge mode
    // while its input is already high does not fabricate a rising edge.
    assign hit         = ev_s & ~(edge_mode & prev);
    assign pend_masked = pend & mask;

    multigate_or16 u_or (
        .a (pend_masked),
        .y (irq_d)
    );

    event_latch16_prienc u_prienc (
        .req (pend_masked),
        .vld (enc_vld),
        .id  (enc_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            pend      <= '0;
            irq       <= 1'b0;
            first_vld <= 1'b0;
            first_id  <= '0;
        end else begin
            prev      <= ev_s;
            // A hit is OR-ed in after the clear so a same-cycle event wins.
            pend      <= (pend & ~clr) | hit;
            irq       <= irq_d;
            first_vld <= enc_vld;
            first_id  <= enc_vld ? enc_id : '0;
        end
    end

endmodule

// File: tb/tb_event_latch16.sv
// tb/tb_event_latch16.sv - directed table-driven bench for event_latch16
module tb_event_latch16;

    logic        clk;
    logic        rst_n;
    logic [15:0] ev_in;
    logic [15:0] edge_mode;
    logic [15:0] mask;
    logic [15:0] clr;
    logic [15:0] pend;
    logic [15:0] pend_masked;
    logic        irq;
    logic        first_vld;
    logic [3:0]  first_id;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] ev;
        logic [15:0] em;
        logic [15:0] mk;
        logic [15:0] cl;
        logic [15:0] exp_pend;
        logic        exp_irq;
        logic        exp_vld;
        logic [3:0]  exp_id;
    } vec_t;

    vec_t vecs[$];

`ifdef EVENT_LATCH16_SYNC_EN
    localparam int CAP_LAT = 3;
`else
    localparam int CAP_LAT = 1;
`endif

    event_latch16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ev_in       (ev_in),
        .edge_mode   (edge_mode),
        .mask        (mask),
        .clr         (clr),
        .pend        (pend),
        .pend_masked (pend_masked),
        .irq         (irq),
        .first_vld   (first_vld),
        .first_id    (first_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] ev, input logic [15:0] em, input logic [15:0] mk,
                       input logic [15:0] cl, input logic [15:0] ep, input logic ei,
                       input logic ev_ok, input logic [3:0] eid);
        vec_t v;
        v.ev = ev; v.em = em; v.mk = mk; v.cl = cl;
        v.exp_pend = ep; v.exp_irq = ei; v.exp_vld = ev_ok; v.exp_id = eid;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        ev_in     = 16'hFFFF;
        edge_mode = 16'h0000;
        mask      = 16'hFFFF;
        clr       = 16'h0000;

        // Reset held with all inputs high: nothing may latch.
        repeat (3) tick();
        check("rst_pend", pend, 16'h0000);
        check("rst_irq", irq, 1'b0);
        check("rst_vld", first_vld, 1'b0);
        check("rst_id", first_id, 4'h0);
        rst_n = 1'b1;

`ifndef EVENT_LATCH16_SYNC_EN
        //   ev        em        mask      clr       pend      irq vld id
        add(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 4'd0);
        add(16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 4'd0);
        add(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        // edge capture on bit 5, held high afterwards
        add(16'h0020, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0020, 0, 0, 4'd0);
        add(16'h0020, 16'hFFFF, 16'hFFFF, 16'h0020, 16'h0000, 1, 1, 4'd5);
        add(16'h0020, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        // set beats clear on bit 3
        add(16'h0008, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0008, 0, 0, 4'd0);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0008, 1, 1, 4'd3);
        add(16'h0008, 16'hFFFF, 16'hFFFF, 16'h0008, 16'h0008, 1, 1, 4'd3);
        add(16'h0008, 16'hFFFF, 16'hFFFF, 16'h0008, 16'h0000, 1, 1, 4'd3);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        // masked channel 9 latches, then unmask
        add(16'h0200, 16'hFFFF, 16'h0000, 16'h0000, 16'h0200, 0, 0, 4'd0);
        add(16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0200, 0, 0, 4'd0);
        add(16'h0000, 16'hFFFF, 16'h0200, 16'h0000, 16'h0200, 1, 1, 4'd9);
        add(16'h0000, 16'hFFFF, 16'h0200, 16'h0200, 16'h0000, 1, 1, 4'd9);
        add(16'h0000, 16'hFFFF, 16'h0200, 16'h0000, 16'h0000, 0, 0, 4'd0);
        // priority walk over 8410
        add(16'h8410, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8410, 0, 0, 4'd0);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8410, 1, 1, 4'd4);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0010, 16'h8400, 1, 1, 4'd4);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8400, 1, 1, 4'd10);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0400, 16'h8000, 1, 1, 4'd10);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000, 1, 1, 4'd15);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000, 1, 1, 4'd15);
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        // clear of already-clear bits
        add(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 4'd0);
        // level mode: clear has no lasting effect while input high
        add(16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 0, 0, 4'd0);
        add(16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 1, 1, 4'd0);
        add(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 4'd0);
        add(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        // switch a high level channel to edge mode: no false hit
        add(16'h0040, 16'h0000, 16'hFFFF, 16'h0000, 16'h0040, 0, 0, 4'd0);
        add(16'h0040, 16'h0040, 16'hFFFF, 16'h0040, 16'h0000, 1, 1, 4'd6);
        add(16'h0040, 16'h0040, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);
        add(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            ev_in     = vecs[i].ev;
            edge_mode = vecs[i].em;
            mask      = vecs[i].mk;
            clr       = vecs[i].cl;
            tick();
            check($sformatf("v%0d_pend", i), pend, vecs[i].exp_pend);
            check($sformatf("v%0d_pmask", i), pend_masked, vecs[i].exp_pend & vecs[i].mk);
            check($sformatf("v%0d_irq", i), irq, vecs[i].exp_irq);
            check($sformatf("v%0d_vld", i), first_vld, vecs[i].exp_vld);
            check($sformatf("v%0d_id", i), first_id, vecs[i].exp_id);
        end
`else
        // Synchronizer: one-cycle pulse on bit 0 reaches pend two edges late.
        edge_mode = 16'hFFFF;
        ev_in     = 16'h0000;
        repeat (3) tick();
        ev_in = 16'h0001;
        tick();
        ev_in = 16'h0000;
        check("sync_n0_pend", pend, 16'h0000);
        tick();
        check("sync_n1_pend", pend, 16'h0000);
        tick();
        check("sync_n2_pend", pend, 16'h0001);
        check("sync_n2_irq", irq, 1'b0);
        tick();
        check("sync_n3_irq", irq, 1'b1);
        check("sync_n3_vld", first_vld, 1'b1);
        check("sync_n3_id", first_id, 4'd0);
        clr = 16'hFFFF;
        tick();
        clr = 16'h0000;
        tick();
        check("sync_clr_pend", pend, 16'h0000);
        check("sync_clr_irq", irq, 1'b0);
`endif

        // Asynchronous reset mid-cycle with state pending.
        edge_mode = 16'h0000;
        mask      = 16'hFFFF;
        clr       = 16'h0000;
        ev_in     = 16'h0100;
        repeat (CAP_LAT) tick();
        check("ar_pend_pre", pend, 16'h0100);
        tick();
        check("ar_irq_pre", irq, 1'b1);
        check("ar_id_pre", first_id, 4'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pend", pend, 16'h0000);
        check("ar_irq", irq, 1'b0);
        check("ar_vld", first_vld, 1'b0);
        check("ar_id", first_id, 4'd0);
        tick();
        check("ar_hold_pend", pend, 16'h0000);
        ev_in = 16'h0000;
        rst_n = 1'b1;
        repeat (CAP_LAT + 1) tick();
        check("ar_after_pend", pend, 16'h0000);
        check("ar_after_irq", irq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
